// File: rtl/jtkcpu_busif.sv
// Byte-wide bus interface for JTKCPU: opcode fetch, operand and data accesses,
// 16-bit accesses as two big-endian byte cycles. Optional bus timeout: JTKCPU_BUSTMO_EN.
module jtkcpu_busif (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic [15:0] pc,
  input  logic [15:0] data_addr,
  input  logic        fetch,
  input  logic        opd,
  input  logic        rdq,
  input  logic        wrq,
  input  logic        memhi,
  input  logic [15:0] wdata,
  input  logic [ 7:0] din,
  input  logic        ready,
  output logic [15:0] addr,
  output logic        we,
  output logic [ 7:0] dout,
  output logic [ 7:0] op,
  output logic [15:0] mdata,
  output logic        mem_busy,
  output logic        buserr
);

  typedef enum logic [2:0] {IDLE, OPC, HI, LO, WRHI, WRLO} state_t;

  state_t      st, st_nx;
  logic        pend, pend_nx, wide, wide_nx;
  logic [ 7:0] wlo, wlo_nx;
  logic [15:0] addr_nx, mdata_nx;
  logic [ 7:0] dout_nx, op_nx;
  logic        we_nx, busy_nx, buserr_nx;
  logic        tmo;

`ifdef JTKCPU_BUSTMO_EN
  logic [7:0] wait_cnt;

  // The 255th consecutive wait cycle aborts instead of counting
  assign tmo = (st != IDLE) && !ready && (wait_cnt == 8'd254);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt <= 8'd0;
    else if (cen)
      wait_cnt <= (st == IDLE || ready || tmo) ? 8'd0 : wait_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      buserr <= 1'b0;
    else if (cen) buserr <= buserr_nx;
  end
`else
  assign tmo    = 1'b0;
  assign buserr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      st <= IDLE;
    else if (cen) st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    case (st)
      IDLE: begin
        if (pend)             st_nx = OPC;
        else if (wrq)         st_nx = memhi ? WRHI : WRLO;
        else if (rdq || opd)  st_nx = memhi ? HI : LO;
        else if (fetch)       st_nx = OPC;
      end
      OPC:     if (ready) st_nx = IDLE;
      HI:      if (ready) st_nx = LO;
      LO:      if (ready) st_nx = IDLE;
      WRHI:    if (ready) st_nx = WRLO;
      WRLO:    if (ready) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
    if (tmo) st_nx = IDLE;
  end

  always_comb begin
    addr_nx   = addr;
    we_nx     = we;
    dout_nx   = dout;
    op_nx     = op;
    mdata_nx  = mdata;
    busy_nx   = mem_busy;
    pend_nx   = pend;
    wide_nx   = wide;
    wlo_nx    = wlo;
    buserr_nx = 1'b0;
    if (st == IDLE) begin
      if (pend) begin
        addr_nx = pc;
        busy_nx = 1'b1;
        pend_nx = 1'b0;
      end else if (wrq) begin
        addr_nx = data_addr;
        we_nx   = 1'b1;
        dout_nx = memhi ? wdata[15:8] : wdata[7:0];
        wlo_nx  = wdata[7:0];
        busy_nx = 1'b1;
        pend_nx = fetch;
      end else if (rdq || opd) begin
        addr_nx = rdq ? data_addr : pc;
        wide_nx = memhi;
        busy_nx = 1'b1;
        pend_nx = fetch;
      end else if (fetch) begin
        addr_nx = pc;
        busy_nx = 1'b1;
      end
    end else begin
      // Busy stays up across completion when a queued fetch follows directly
      pend_nx = pend | fetch;
      if (ready) begin
        case (st)
          OPC: begin
            op_nx   = din;
            busy_nx = pend_nx;
          end
          HI: begin
            mdata_nx[15:8] = din;
            addr_nx        = addr + 16'd1;
          end
          LO: begin
            mdata_nx = wide ? {mdata[15:8], din} : {8'h00, din};
            busy_nx  = pend_nx;
          end
          WRHI: begin
            addr_nx = addr + 16'd1;
            dout_nx = wlo;
          end
          WRLO: begin
            we_nx   = 1'b0;
            busy_nx = pend_nx;
          end
          default: ;
        endcase
      end
      if (tmo) begin
        if (st == OPC)            op_nx    = 8'hFF;
        if (st == HI || st == LO) mdata_nx = 16'hFFFF;
        we_nx     = 1'b0;
        busy_nx   = 1'b0;
        buserr_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= 16'd0;
      we       <= 1'b0;
      dout     <= 8'd0;
      op       <= 8'd0;
      mdata    <= 16'd0;
      mem_busy <= 1'b0;
      pend     <= 1'b0;
      wide     <= 1'b0;
      wlo      <= 8'd0;
    end else if (cen) begin
      addr     <= addr_nx;
      we       <= we_nx;
      dout     <= dout_nx;
      op       <= op_nx;
      mdata    <= mdata_nx;
      mem_busy <= busy_nx;
      pend     <= pend_nx;
      wide     <= wide_nx;
      wlo      <= wlo_nx;
    end
  end

endmodule

// File: tb/tb_jtkcpu_busif.sv
// Directed self-checking bench for jtkcpu_busif.
module tb_jtkcpu_busif;
  logic        rst, clk, cen;
  logic [15:0] pc, data_addr, wdata;
  logic        fetch, opd, rdq, wrq, memhi, ready;
  logic [ 7:0] din;
  logic [15:0] addr, mdata;
  logic        we, mem_busy, buserr;
  logic [ 7:0] dout, op;
  int          n_chk = 0, n_pass = 0;

  jtkcpu_busif dut (
    .rst(rst), .clk(clk), .cen(cen), .pc(pc), .data_addr(data_addr),
    .fetch(fetch), .opd(opd), .rdq(rdq), .wrq(wrq), .memhi(memhi),
    .wdata(wdata), .din(din), .ready(ready), .addr(addr), .we(we),
    .dout(dout), .op(op), .mdata(mdata), .mem_busy(mem_busy), .buserr(buserr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " addr"}, addr, 16'h0000);
    chk({tag, " we"}, {15'd0, we}, 16'd0);
    chk({tag, " dout"}, {8'd0, dout}, 16'd0);
    chk({tag, " op"}, {8'd0, op}, 16'd0);
    chk({tag, " mdata"}, mdata, 16'h0000);
    chk({tag, " busy"}, {15'd0, mem_busy}, 16'd0);
    chk({tag, " buserr"}, {15'd0, buserr}, 16'd0);
  endtask

  initial begin
    int berr_cnt;
    rst = 1'b1; cen = 1'b1; pc = '0; data_addr = '0; wdata = '0;
    fetch = 0; opd = 0; rdq = 0; wrq = 0; memhi = 0; ready = 1; din = '0;
    tick; tick;
    chk_zero("reset");
    rst = 1'b0;

    // opcode fetch
    fetch = 1; pc = 16'h1000; din = 8'h86;
    tick; chk("fetch addr", addr, 16'h1000); chk("fetch busy", {15'd0, mem_busy}, 16'd1);
    fetch = 0;
    tick; chk("fetch op", {8'd0, op}, 16'h0086); chk("fetch busy end", {15'd0, mem_busy}, 16'd0);

    // 16-bit read wrapping the address
    rdq = 1; memhi = 1; data_addr = 16'hFFFF; din = 8'h12;
    tick; chk("rd16 addr hi", addr, 16'hFFFF); chk("rd16 busy1", {15'd0, mem_busy}, 16'd1);
    rdq = 0; memhi = 0;
    tick; chk("rd16 addr wrap", addr, 16'h0000); chk("rd16 busy2", {15'd0, mem_busy}, 16'd1);
    chk("rd16 mdata part", mdata, 16'h1200);
    din = 8'h34;
    tick; chk("rd16 mdata", mdata, 16'h1234); chk("rd16 busy end", {15'd0, mem_busy}, 16'd0);

    // 16-bit write with three wait states on the high byte
    wrq = 1; memhi = 1; wdata = 16'hBEEF; data_addr = 16'h2000; ready = 0;
    tick; chk("wr addr hi", addr, 16'h2000); chk("wr we", {15'd0, we}, 16'd1);
    chk("wr dout hi", {8'd0, dout}, 16'h00BE);
    wrq = 0; memhi = 0; wdata = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("wr wait addr", addr, 16'h2000); chk("wr wait we", {15'd0, we}, 16'd1);
      chk("wr wait dout", {8'd0, dout}, 16'h00BE); chk("wr wait busy", {15'd0, mem_busy}, 16'd1);
    end
    ready = 1;
    tick; chk("wr addr lo", addr, 16'h2001); chk("wr dout lo", {8'd0, dout}, 16'h00EF);
    chk("wr we lo", {15'd0, we}, 16'd1); chk("wr busy lo", {15'd0, mem_busy}, 16'd1);
    tick; chk("wr we end", {15'd0, we}, 16'd0); chk("wr busy end", {15'd0, mem_busy}, 16'd0);

    // fetch colliding with a read: read first, fetch follows
    fetch = 1; rdq = 1; pc = 16'h3000; data_addr = 16'h4000; din = 8'h55;
    tick; chk("col rd addr", addr, 16'h4000);
    fetch = 0; rdq = 0;
    tick; chk("col mdata", mdata, 16'h0055); chk("col op held", {8'd0, op}, 16'h0086);
    chk("col busy held", {15'd0, mem_busy}, 16'd1);
    din = 8'h77;
    tick; chk("col fetch addr", addr, 16'h3000); chk("col busy fetch", {15'd0, mem_busy}, 16'd1);
    tick; chk("col op", {8'd0, op}, 16'h0077); chk("col busy end", {15'd0, mem_busy}, 16'd0);
    chk("col mdata kept", mdata, 16'h0055);

    // cen low freezes everything
    opd = 1; pc = 16'h5000; din = 8'h9A; cen = 0;
    tick; chk("cen0 addr", addr, 16'h3000); chk("cen0 busy", {15'd0, mem_busy}, 16'd0);
    cen = 1;
    tick; chk("opd addr", addr, 16'h5000);
    opd = 0; cen = 0;
    tick; chk("cen0 mdata", mdata, 16'h0055); chk("cen0 busy2", {15'd0, mem_busy}, 16'd1);
    cen = 1;
    tick; chk("opd mdata", mdata, 16'h009A);

    // reset in LO of a 16-bit read
    rdq = 1; memhi = 1; data_addr = 16'h6000; din = 8'hAB;
    tick; rdq = 0; memhi = 0;
    tick; chk("rst pre mdata", mdata, 16'hAB9A);
    #2 rst = 1; #1;
    chk_zero("midrst");
    tick; rst = 0;

    // stuck bus
    rdq = 1; ready = 0; data_addr = 16'h7000;
    tick; rdq = 0;
    berr_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick;
      if (buserr) berr_cnt++;
    end
`ifdef JTKCPU_BUSTMO_EN
    chk("tmo buserr count", 16'(berr_cnt), 16'd1);
    chk("tmo mdata", mdata, 16'hFFFF);
    chk("tmo busy", {15'd0, mem_busy}, 16'd0);
`else
    chk("notmo buserr count", 16'(berr_cnt), 16'd0);
    chk("notmo busy", {15'd0, mem_busy}, 16'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/jtkcpu_busif.md
# jtkcpu_busif

Byte-wide memory bus interface for the JTKCPU core. It sits directly upstream of the control unit. It runs opcode fetches, operand reads and data reads/writes on the external 8-bit bus, and presents the results to the control unit as `op` and `mdata`. It assembles 16-bit accesses from two big-endian byte cycles, honours bus wait states, and drives `mem_busy` so microcode stalls until the access finishes.

## Interface
- No parameters.
- `rst`  in  1  asynchronous reset, active-high
- `clk`  in  1  clock
- `cen`  in  1  clock enable; all state advances only when high
- `pc`  in  16  program counter from control unit
- `data_addr`  in  16  effective data address (indexed/direct/stack)
- `fetch`  in  1  request opcode read at `pc`
- `opd`  in  1  request operand read at `pc` (8 or 16 bits per `memhi`)
- `rdq`  in  1  request data read at `data_addr`
- `wrq`  in  1  request data write at `data_addr`
- `memhi`  in  1  sampled with request: 1 = 16-bit access, 0 = 8-bit
- `wdata`  in  16  write data; 8-bit writes use `wdata[7:0]`
- `din`  in  8  bus read data
- `ready`  in  1  bus ready; low inserts wait states
- `addr`  out  16  bus address
- `we`  out  1  bus write strobe
- `dout`  out  8  bus write data
- `op`  out  8  latched opcode
- `mdata`  out  16  latched read data; 8-bit reads zero-extend into `[7:0]`
- `mem_busy`  out  1  access in progress
- `buserr`  out  1  one-cen pulse on bus timeout (see Configuration)

## Operation
- States: IDLE, OPC, HI, LO, plus WRHI and WRLO for writes.
- Requests are sampled in IDLE on `cen`.
- Request priority: `wrq` > `rdq` > `opd` > `fetch`.
- A losing `fetch` is held in a one-deep pending bit. It is issued on the next return to IDLE. No other request is queued.
- Requests arriving while not in IDLE are ignored, except `fetch`, which sets the pending bit.
- fetch: `addr`<=`pc`, go to OPC. When `ready`, `op`<=`din`, go to IDLE.
- 8-bit read (`opd` or `rdq`, `memhi`=0): go to LO at the base address. When `ready`, `mdata`<={8'h00,`din`}.
- 16-bit read: go to HI at the base address. When `ready`, `mdata[15:8]`<=`din`, `addr`<=`addr`+1, go to LO. When `ready`, `mdata[7:0]`<=`din`.
- Writes follow the same sequence through WRHI/WRLO. `dout` carries `wdata[15:8]` then `wdata[7:0]`, with `we`=1 in those states.
- Address increment wraps: 16'hFFFF+1 = 16'h0000.
- `mem_busy` is high from the cycle after a request is accepted through the cycle the final byte is latched. It is low in IDLE unless a pending fetch is being issued.
- Reset values: state IDLE, pending 0, `addr` 0, `we` 0, `dout` 0, `op` 0, `mdata` 0, `mem_busy` 0, `buserr` 0.
- Reset mid-access aborts immediately to these values. Partially assembled `mdata` is cleared.

## Timing
- Zero-wait 8-bit access: request at cen edge N, data latched at edge N+1. `mem_busy` is high for exactly 1 cen cycle.
- Zero-wait 16-bit access: 2 cen cycles. Each low-`ready` cen cycle adds one cycle.
- `op` and `mdata` are valid in the cycle `mem_busy` falls and hold until the next completed access of the same kind.
- `we` is never asserted in the same cycle as an address change to a read address.
- Cycles with `cen` low freeze all outputs.

## Configuration
- `JTKCPU_BUSTMO_EN`
- Defined: an 8-bit wait counter increments on each cen cycle in a non-IDLE state with `ready` low, and clears when `ready` is high. When it reaches 255, the access aborts:
  - reads set `mdata`<=16'hFFFF (`op`<=8'hFF for fetch);
  - `buserr` pulses for one cen cycle;
  - state returns to IDLE and `mem_busy` drops.
- Undefined: no counter, waits indefinitely, `buserr` tied 0.

## Test plan
- Reset with `rst`=1 -> every output 0, state IDLE. Release, then `fetch` at `pc`=16'h1000 with `din`=8'h86 -> `addr`=16'h1000, `op`=8'h86 after 1 cen, `mem_busy` high 1 cycle.
- `rdq`+`memhi` at `data_addr`=16'hFFFF, `din` 8'h12 then 8'h34 -> second `addr`=16'h0000, `mdata`=16'h1234, `mem_busy` high 2 cycles.
- `wrq`+`memhi`, `wdata`=16'hBEEF at 16'h2000, `ready` low 3 cycles on the first byte -> `dout` 8'hBE at 16'h2000 held with `we`=1 for 4 cycles, then 8'hEF at 16'h2001, total busy 5 cycles.
- `fetch` and `rdq` in the same cycle -> read runs first. Fetch issues immediately after without being lost, and `op` is updated after `mdata`.
- Assert `rst` during the LO state of a 16-bit read -> all outputs 0 in the same cycle, `mdata` not partially updated.
- With `JTKCPU_BUSTMO_EN`, `ready` held low on an 8-bit read -> after 255 wait cycles `buserr` pulses once, `mdata`=16'hFFFF, `mem_busy`=0. Without the macro, `mem_busy` remains 1.
